// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared definitions for the UART program loader: loader state
//               encoding and UART frame shape (8 data bits, 1 stop bit).
//               The S_SUM state exists only when PROG_LOADER_CHECKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_SUM  = 3'd2,
`endif
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Instruction-memory write port driven by the program loader.
//               Ports : we    - one-cycle write strobe
//                       addr  - word address (ADDR_W bits)
//                       wdata - 32-bit write data
//               Modports: master (loader side), slave (memory side).
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, idle high.
//               Ports : clk, reset_n (async active-low)
//                       i_rxd        - asynchronous serial input
//                       o_valid      - one-cycle pulse, byte in o_data
//                       o_data       - received byte (held until next byte)
//                       o_frame_err  - one-cycle pulse on a zero stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  wire        clk,
    input  wire        reset_n,
    input  wire        i_rxd,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);
    import prog_loader_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]       r_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;
    logic             w_rxd;

    assign w_rxd = r_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!w_rxd) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit in: still low means a real start bit, and
                    // every later sample lands in the middle of its bit.
                    if (r_cnt == C_HALF_M1) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= w_rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == C_FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd, r_shift[7:1]};
                        if (r_bit == 3'(UART_DATA_BITS - 1)) begin
                            r_bit   <= '0;
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == C_FULL_M1) begin
                        r_cnt <= '0;
                        if (!w_rxd) begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_IDLE;
                        end else if (r_bit == 3'(UART_STOP_BITS - 1)) begin
                            r_valid <= 1'b1;
                            r_state <= RX_IDLE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_shift;
    assign o_frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : UART boot loader. Receives a 32-bit word count N followed by
//               N 32-bit words (little-endian bytes) and writes them to
//               instruction memory at addresses 0..N-1, then releases the
//               CPU reset. Optional macro PROG_LOADER_CHECKSUM_EN adds a
//               trailing checksum word (mod 2**32 sum of the data words).
//               Ports : clk, reset_n (async active-low), uart_rxd
//                       imem        - prog_loader_if.master write port
//                       cpu_reset_n - CPU reset, high once the load is done
//                       loading     - high while a load is in progress
//                       err         - sticky error (framing/length/checksum)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int ADDR_W       = 10
) (
    input  wire            clk,
    input  wire            reset_n,
    input  wire            uart_rxd,
    prog_loader_if.master  imem,
    output logic           cpu_reset_n,
    output logic           loading,
    output logic           err
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              w_rx_ferr;
    logic              w_loading;
    logic              w_word_done;
    logic [31:0]       w_word;

    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rxd       (uart_rxd),
        .o_valid     (w_rx_valid),
        .o_data      (w_rx_data),
        .o_frame_err (w_rx_ferr)
    );

    always_comb begin
        w_loading = (r_state == S_LEN) || (r_state == S_DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (r_state == S_SUM) begin
            w_loading = 1'b1;
        end
`endif
    end

    // New byte enters at the top, so after four bytes the first one sits in
    // bits 7:0.
    assign w_word      = {w_rx_data, r_word[31:8]};
    assign w_word_done = w_rx_valid && w_loading && (r_byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_LEN;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_rx_valid && w_loading) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_word     <= w_word;
            end
            case (r_state)
                S_LEN: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                    end else if (w_word_done) begin
                        if (w_word == 32'd0) begin
                            r_state <= S_RUN;
                        end else if (w_word > 32'(DEPTH)) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_DATA;
                            r_len   <= w_word[ADDR_W:0];
                            r_idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_sum   <= '0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                    end else if (r_we && (r_idx == r_len)) begin
                        // Leave during the final write strobe so the CPU
                        // reset releases on the following cycle.
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state <= S_SUM;
`else
                        r_state <= S_RUN;
`endif
                    end else if (w_word_done) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_idx[ADDR_W-1:0];
                        r_wdata <= w_word;
                        r_idx   <= r_idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + w_word;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_SUM: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                    end else if (w_word_done) begin
                        r_state <= (w_word == r_sum) ? S_RUN : S_ERR;
                    end
                end
`endif
                // Bytes and framing errors after a finished load are ignored;
                // S_ERR is left only through reset_n.
                S_RUN:   r_state <= S_RUN;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign imem.we     = r_we;
    assign imem.addr   = r_addr;
    assign imem.wdata  = r_wdata;
    assign cpu_reset_n = (r_state == S_RUN);
    assign err         = (r_state == S_ERR);
    assign loading     = w_loading;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader (CLKS_PER_BIT=4,
//               ADDR_W=4). Drives UART frames, collects memory writes and
//               compares them with the writes predicted from the sent byte
//               stream. Honors PROG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int CPB    = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic uart_rxd;
    logic cpu_reset_n;
    logic loading;
    logic err;

    prog_loader_if #(.ADDR_W(ADDR_W)) imem ();

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_rxd    (uart_rxd),
        .imem        (imem.master),
        .cpu_reset_n (cpu_reset_n),
        .loading     (loading),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write/event monitor, sampled on the falling edge.
    int   wr_addr[$];
    logic [31:0] wr_data[$];
    int   cyc = 0;
    int   last_we_cyc = -100, cpu_rise_cyc = -200, load_fall_cyc = -300, last_rxv_cyc = -400;
    logic prev_cpu = 1'b0, prev_load = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (imem.we) begin
            wr_addr.push_back(int'(imem.addr));
            wr_data.push_back(imem.wdata);
            last_we_cyc = cyc;
        end
        if (cpu_reset_n && !prev_cpu) cpu_rise_cyc = cyc;
        if (!loading && prev_load)    load_fall_cyc = cyc;
        if (dut.u_uart_rx.o_valid)    last_rxv_cyc = cyc;
        prev_cpu  = cpu_reset_n;
        prev_load = loading;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends a length word, the data words and (when enabled) the checksum;
    // bad_sum corrupts the checksum.
    task automatic send_load(input int n, input logic [31:0] words[$], input bit bad_sum);
        logic [31:0] sum;
        sum = 32'd0;
        send_word(32'(n));
        foreach (words[i]) begin
            send_word(words[i]);
            sum += words[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (n >= 1 && n <= DEPTH) send_word(bad_sum ? sum + 32'd1 : sum);
`else
        if (bad_sum) sum = 32'd0;
`endif
        repeat (6) @(negedge clk);
    endtask

    // Reference: a good load of n words leaves exactly n writes, word i at
    // address i, CPU released, no error; a rejected load leaves no writes
    // unless it failed at the checksum stage.
    task automatic check_load(input string tag, input int n, input logic [31:0] words[$], input bit ok, input bit writes_expected);
        int nexp;
        nexp = writes_expected ? n : 0;
        check({tag, "_wr_cnt"}, 64'(wr_addr.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(words[i]));
        end
        check({tag, "_err"}, 64'(err), 64'(!ok));
        check({tag, "_cpu_rst_n"}, 64'(cpu_reset_n), 64'(ok));
        check({tag, "_loading"}, 64'(loading), 64'd0);
        if (nexp > 0) begin
            check({tag, "_addr_hold"}, 64'(imem.addr), 64'(n - 1));
            check({tag, "_wdata_hold"}, 64'(imem.wdata), 64'(words[n-1]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(imem.we), 64'd0);
        check({tag, "_addr"}, 64'(imem.addr), 64'd0);
        check({tag, "_wdata"}, 64'(imem.wdata), 64'd0);
        check({tag, "_cpu_rst_n"}, 64'(cpu_reset_n), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_loading"}, 64'(loading), 64'd1);
    endtask

    logic [31:0] wq[$];
    int          n;

    initial begin
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        #1;
        check_reset_outputs("rst");
        do_reset();

        // Two-word directed load with release timing.
        wq = '{32'h0000_0013, 32'hDEAD_BEEF};
        send_load(2, wq, 1'b0);
        check_load("two", 2, wq, 1'b1, 1'b1);
`ifndef PROG_LOADER_CHECKSUM_EN
        check("two_cpu_lag", 64'(cpu_rise_cyc - last_we_cyc), 64'd1);
`endif
        check("two_load_fall", 64'(load_fall_cyc), 64'(cpu_rise_cyc));

        // Empty program.
        do_reset();
        wq = {};
        send_load(0, wq, 1'b0);
        check_load("zero", 0, wq, 1'b1, 1'b0);
        check("zero_cpu_lag", 64'(cpu_rise_cyc - last_rxv_cyc), 64'd1);

        // Randomized loads, including full depth, followed by ignored bytes.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            n = (k == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            wq = {};
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_load(n, wq, 1'b0);
            send_byte(8'($urandom), 1'b1);
            send_byte(8'($urandom), 1'b1);
            check_load($sformatf("rnd%0d", k), n, wq, 1'b1, 1'b1);
        end

        // Framing error on the first length byte, then four good frames.
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("ferr_err", 64'(err), 64'd1);
        check("ferr_cpu_rst_n", 64'(cpu_reset_n), 64'd0);
        check("ferr_wr_cnt", 64'(wr_addr.size()), 64'd0);

        // One-cycle glitch in idle, then a normal one-word load.
        do_reset();
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        wq = '{$urandom};
        send_load(1, wq, 1'b0);
        check_load("glitch", 1, wq, 1'b1, 1'b1);

        // Length beyond memory depth.
        do_reset();
        wq = {};
        send_word(32'd17);
        send_word(32'h1234_5678);
        check_load("len17", 17, wq, 1'b0, 1'b0);

        // Reset in the middle of a data byte; next load starts from scratch.
        do_reset();
        send_word(32'd3);
        send_word(32'hCAFE_F00D);
        send_byte(8'hAA, 1'b1);
        uart_rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        wq = '{32'h0BAD_C0DE};
        send_load(1, wq, 1'b0);
        check_load("after_rst", 1, wq, 1'b1, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        wq = '{32'h0000_0005};
        send_load(1, wq, 1'b0);
        check_load("csum_ok", 1, wq, 1'b1, 1'b1);
        do_reset();
        send_load(1, wq, 1'b1);
        check_load("csum_bad", 1, wq, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
